// File: rtl/osnt_sume_10g_rx_ts_extract.sv
// RX timestamp extraction: passes AXI-Stream beats through one register stage and
// reports latency and sequence statistics for packets that carry an embedded TX timestamp.
module osnt_sume_10g_rx_ts_extract #(
    parameter int C_M_AXIS_DATA_WIDTH  = 64,
    parameter int C_S_AXIS_DATA_WIDTH  = 64,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int TS_WIDTH             = 64
) (
    input  logic                                 axis_aclk,
    input  logic                                 axis_resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic                                 s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        rx_ts_pos,
    input  logic [TS_WIDTH-1:0]                  timestamp_156,
    input  logic                                 clear,
    output logic                                 lat_valid,
    output logic [TS_WIDTH-1:0]                  lat_value,
    output logic [31:0]                          lat_seq,
    output logic [31:0]                          sig_pkt_count,
    output logic [31:0]                          seq_gap_count,
    output logic [TS_WIDTH-1:0]                  lat_min,
    output logic [TS_WIDTH-1:0]                  lat_max
);
    localparam logic [31:0]                   SIGNATURE = 32'hefbeadde;
    localparam logic [C_S_AXI_DATA_WIDTH-1:0] ONE       = 1;

    typedef enum logic {ST_SOF, ST_MID} state_t;

    state_t                        state;
    logic [C_S_AXI_DATA_WIDTH-1:0] word_cnt;
    logic [TS_WIDTH-1:0]           rx_ts, tx_ts;
    logic [31:0]                   seq, last_seq;
    logic                          sig_ok, first_seen;

    logic                          in_fire, done;
    logic [TS_WIDTH-1:0]           cur_rx, cur_tx, new_lat;
    logic [31:0]                   cur_seq;
    logic                          cur_sig;

    assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
    assign in_fire       = s_axis_tvalid & s_axis_tready;

    // Per-beat view of packet state including the effect of the beat being accepted now,
    // so a signature on the tlast beat completes the packet in the same cycle.
    always_comb begin
        cur_rx  = (state == ST_SOF) ? timestamp_156 : rx_ts;
        cur_tx  = tx_ts;
        cur_seq = seq;
        cur_sig = (state == ST_SOF) ? 1'b0 : sig_ok;
        if (rx_ts_pos != '0) begin
            if (word_cnt == rx_ts_pos)
                cur_tx = s_axis_tdata[TS_WIDTH-1:0];
            if (word_cnt == rx_ts_pos + ONE) begin
                cur_sig = (s_axis_tdata[31:0] == SIGNATURE);
                cur_seq = s_axis_tdata[63:32];
            end
        end
        done    = in_fire & s_axis_tlast & cur_sig;
        new_lat = cur_rx - cur_tx;
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (in_fire) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tuser  <= s_axis_tuser;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state    <= ST_SOF;
            word_cnt <= ONE;
            rx_ts    <= '0;
            tx_ts    <= '0;
            seq      <= '0;
            sig_ok   <= 1'b0;
        end else if (in_fire) begin
            rx_ts  <= cur_rx;
            tx_ts  <= cur_tx;
            seq    <= cur_seq;
            sig_ok <= cur_sig;
            if (s_axis_tlast) begin
                state    <= ST_SOF;
                word_cnt <= ONE;
            end else begin
                state <= ST_MID;
                if (word_cnt != '1)
                    word_cnt <= word_cnt + ONE;
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            lat_valid     <= 1'b0;
            lat_value     <= '0;
            lat_seq       <= '0;
            sig_pkt_count <= '0;
            seq_gap_count <= '0;
            lat_min       <= '1;
            lat_max       <= '0;
            last_seq      <= '0;
            first_seen    <= 1'b0;
        end else begin
            lat_valid <= done;
            if (done) begin
                lat_value <= new_lat;
                lat_seq   <= cur_seq;
                last_seq  <= cur_seq;
            end
            // Clear takes priority over a coinciding completion for the statistics only.
            if (clear) begin
                sig_pkt_count <= '0;
                seq_gap_count <= '0;
                lat_min       <= '1;
                lat_max       <= '0;
                first_seen    <= 1'b0;
            end else if (done) begin
                sig_pkt_count <= sig_pkt_count + 32'd1;
                if (first_seen && (cur_seq != last_seq + 32'd1))
                    seq_gap_count <= seq_gap_count + 32'd1;
                first_seen <= 1'b1;
                if (new_lat < lat_min) lat_min <= new_lat;
                if (new_lat > lat_max) lat_max <= new_lat;
            end
        end
    end
endmodule
